// File: rtl/sequential_sign_magnitude_multiplier.sv
// ============================================================================
// Module   : sequential_sign_magnitude_multiplier
// Function : Shift-add multiplier on unsigned magnitudes, with the XOR of the
//            operand signs applied to give a two's complement product.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sequential_sign_magnitude_multiplier #(
    parameter int WORD_LENGTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [WORD_LENGTH-1:0]     multiplicand_mag,
    input  logic                       multiplicand_sign,
    input  logic [WORD_LENGTH-1:0]     multiplier_mag,
    input  logic                       multiplier_sign,
    output logic                       ready,
    output logic                       done,
    output logic [2*WORD_LENGTH-1:0]   product
);

    localparam int PW    = 2 * WORD_LENGTH;
    localparam int CNT_W = (WORD_LENGTH > 1) ? $clog2(WORD_LENGTH) : 1;
    localparam logic [CNT_W-1:0] c_last_count = CNT_W'(WORD_LENGTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                 r_state;
    logic [PW-1:0]          r_mcand;
    logic [WORD_LENGTH-1:0] r_mplier;
    logic [PW-1:0]          r_acc;
    logic [CNT_W-1:0]       r_count;
    logic                   r_sign;

    logic [PW-1:0]          w_acc_next;
    logic [PW-1:0]          w_acc_neg;

    // The final add must be folded in before the product is loaded.
    assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : {PW{1'b0}});
    assign w_acc_neg  = (~w_acc_next) + PW'(1);

    assign ready = (r_state == S_IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_count  <= '0;
            r_sign   <= 1'b0;
            done     <= 1'b0;
            product  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        r_mcand  <= {{WORD_LENGTH{1'b0}}, multiplicand_mag};
                        r_mplier <= multiplier_mag;
                        r_sign   <= multiplicand_sign ^ multiplier_sign;
                        r_acc    <= '0;
                        r_count  <= '0;
                        r_state  <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_acc    <= w_acc_next;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_count  <= r_count + CNT_W'(1);
                    if (r_count == c_last_count) begin
                        product <= r_sign ? w_acc_neg : w_acc_next;
                        done    <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    done    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    done    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
